ov7670_stream_gen: RTL and testbench

- Synthesizable OV7670 camera emulator: the transmitting end of the camera pixel bus that the OV7670 capture path and frame buffer receive.
- Drives pclk, vsync, href and an 8-bit RGB565 byte stream (two bytes per pixel) with a selectable test pattern, using the same framing the capture controller expects.
- Substitutes for a physical camera on CAM1/CAM2 inputs for bring-up, frame-buffer verification and loopback demos.

---
 rtl/ov7670_stream_gen.sv | 153 +++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
//   Emulates the transmit side of an OV7670 pixel bus. It produces pclk,
//   vsync, href and an RGB565 byte stream (high byte first) carrying one of
//   four test patterns, using the framing the capture path expects.
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   enable            start/continue frames (sampled at a frame boundary)
//   pattern_sel[1:0]  pattern for the next frame (latched at frame start)
//   pclk              emulated pixel clock, clk / CLK_DIV
//   vsync, href       frame and line framing, active high
//   data[7:0]         pixel byte; 0 whenever href is low
//   frame_cnt[7:0]    number of completed frames (wraps)
//   frame_done        one-clk pulse when a frame's last blank line ends
module ov7670_stream_gen #(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int CLK_DIV     = 4,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_FRONT     = 17,
    parameter int V_BACK      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic [7:0] frame_cnt,
    output logic       frame_done
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [15:0] H_LAST   = 16'(2 * IMG_WIDTH + H_BLANK - 1);
    localparam logic [15:0] H_ACT    = 16'(2 * IMG_WIDTH);
    localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
    localparam logic [15:0] ACT_LAST = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] BAR_W    = 16'(IMG_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, VSYNC, VFRONT, ACTIVE, VBACK} state_t;

    state_t        state, nxt_state;
    logic [DW-1:0] div_cnt;
    logic [15:0]   h_cnt, v_cnt, nxt_h, nxt_v;
    logic [1:0]    pat;
    logic          slot_end, frame_end;
    logic [15:0]   px_x, bar, rgb;
    logic          nxt_href;
    logic [7:0]    nxt_byte;

    assign slot_end = (div_cnt == DIV_LAST);
    assign pclk     = (div_cnt >= DIV_HALF);

    // Position of the slot that starts at the next slot boundary. The bus
    // registers are loaded from this position, so outputs change at pclk
    // falling and describe the slot the receiver samples next.
    always_comb begin
        nxt_state = state;
        nxt_h     = h_cnt;
        nxt_v     = v_cnt;
        frame_end = 1'b0;
        if (state == IDLE) begin
            nxt_h = '0;
            nxt_v = '0;
            if (enable) nxt_state = VSYNC;
        end else if (h_cnt != H_LAST) begin
            nxt_h = h_cnt + 16'd1;
        end else begin
            nxt_h = '0;
            nxt_v = v_cnt + 16'd1;
            case (state)
                VSYNC:  if (v_cnt == VS_LAST)  begin nxt_state = VFRONT; nxt_v = '0; end
                VFRONT: if (v_cnt == VF_LAST)  begin nxt_state = ACTIVE; nxt_v = '0; end
                ACTIVE: if (v_cnt == ACT_LAST) begin nxt_state = VBACK;  nxt_v = '0; end
                VBACK: begin
                    if (v_cnt == VB_LAST) begin
                        nxt_v     = '0;
                        frame_end = 1'b1;
                        nxt_state = enable ? VSYNC : IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern generator for the next slot's pixel (x = slot/2, y = line).
    always_comb begin
        px_x = {1'b0, nxt_h[15:1]};
        bar  = px_x / BAR_W;
        rgb  = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar)
                    16'd0:   rgb = 16'hFFFF;
                    16'd1:   rgb = 16'hFFE0;
                    16'd2:   rgb = 16'h07FF;
                    16'd3:   rgb = 16'h07E0;
                    16'd4:   rgb = 16'hF81F;
                    16'd5:   rgb = 16'hF800;
                    16'd6:   rgb = 16'h001F;
                    default: rgb = 16'h0000;
                endcase
            end
            2'd1:    rgb = {px_x[7:3], px_x[7:2], px_x[7:3]};
            2'd2:    rgb = (px_x[3] ^ nxt_v[3]) ? 16'hFFFF : 16'h0000;
            default: rgb = {frame_cnt[4:0], 6'h00, ~frame_cnt[4:0]};
        endcase
        nxt_href = (nxt_state == ACTIVE) && (nxt_h < H_ACT);
        nxt_byte = nxt_h[0] ? rgb[7:0] : rgb[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            pat        <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            frame_cnt  <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (slot_end) begin
                div_cnt <= '0;
                state   <= nxt_state;
                h_cnt   <= nxt_h;
                v_cnt   <= nxt_v;
                // Entering VSYNC from IDLE or VBACK is the frame boundary.
                if (nxt_state == VSYNC && state != VSYNC) pat <= pattern_sel;
                vsync <= (nxt_state == VSYNC);
                href  <= nxt_href;
                data  <= nxt_href ? nxt_byte : 8'h00;
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Testbench for ov7670_stream_gen on a reduced geometry: every pixel byte is
// checked against a scoreboard filled from a reference model when each
// frame's pattern is driven, framing widths are measured in pclk slots, and
// selected pixels of captured frames are compared against a constant table.
module tb_ov7670_stream_gen;

    localparam int IW = 16, IH = 16, CD = 4, HB = 8, VS = 2, VF = 3, VB = 2;
    localparam int L = 2 * IW + HB;
    localparam int FRAME_SLOTS = (VS + VF + IH + VB) * L;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       pclk, vsync, href, frame_done;
    logic [7:0] data, frame_cnt;

    ov7670_stream_gen #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .CLK_DIV(CD), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_FRONT(VF), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data),
        .frame_cnt(frame_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model and scoreboard ----------------
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  sb [$];

    function automatic logic [15:0] model_rgb(int pat, int x, int y, int fc);
        logic [7:0] xb;
        logic [4:0] f;
        xb = 8'(x);
        f  = 5'(fc);
        case (pat)
            0:       return bars[x / (IW / 8)];
            1:       return {xb[7:3], xb[7:2], xb[7:3]};
            2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return {f, 6'h00, ~f};
        endcase
    endfunction

    function automatic void push_frame(int pat, int fc);
        logic [15:0] p;
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
                p = model_rgb(pat, x, y, fc);
                sb.push_back(p[15:8]);
                sb.push_back(p[7:0]);
            end
    endfunction

    // ---------------- monitor ----------------
    logic [15:0] fb [8][IH][IW];
    int   slot, vs_rise_slot, hr_rise_slot, line, bidx, n_done;
    int   mon_frame = 0;
    bit   pclk_q, vs_q, hr_q, have_prev, first_pend, fd_q;
    logic [7:0] hi_b, rise_data, exp_b;

    always @(negedge clk) begin
        if (reset) begin
            slot = 0; pclk_q = 0; vs_q = 0; hr_q = 0; have_prev = 0;
            first_pend = 0; fd_q = 0; n_done = 0; line = 0; bidx = 0;
        end else begin
            if (pclk && !pclk_q) begin
                slot++;
                rise_data = data;
                if (!href) check("blank_data", int'(data), 0);
                if (vsync && !vs_q) begin
                    if (have_prev) check("frame_period", slot - vs_rise_slot, FRAME_SLOTS);
                    have_prev = 1; vs_rise_slot = slot; first_pend = 1; line = 0;
                end
                if (!vsync && vs_q) check("vsync_width", slot - vs_rise_slot, VS * L);
                if (href && !hr_q) begin
                    hr_rise_slot = slot; bidx = 0;
                    if (first_pend) begin
                        check("vsync_to_href", slot - vs_rise_slot, (VS + VF) * L);
                        first_pend = 0;
                    end
                end
                if (!href && hr_q) begin
                    check("href_width", slot - hr_rise_slot, 2 * IW);
                    line++;
                end
                if (href) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_underflow: got byte %0h with no expected byte queued", data);
                    end else begin
                        exp_b = sb.pop_front();
                        check("sb_byte", int'(data), int'(exp_b));
                    end
                    if (bidx % 2 == 0) hi_b = data;
                    else if (mon_frame < 8 && line < IH && bidx / 2 < IW)
                        fb[mon_frame][line][bidx / 2] = {hi_b, data};
                    bidx++;
                end
                vs_q = vsync; hr_q = href;
            end else if (pclk && pclk_q) begin
                check("data_stable", int'(data), int'(rise_data));
            end
            pclk_q = pclk;
            if (frame_done) begin
                check("done_one_clk", int'(fd_q), 0);
                n_done++;
                check("frame_cnt", int'(frame_cnt), n_done & 255);
                check("b2b_vsync", int'(vsync), int'(enable));
                mon_frame++;
                if (!enable) have_prev = 0;
            end
            fd_q = frame_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic release_check();
        int n = 0;
        @(negedge clk);
        reset = 1'b0;
        while (!vsync && n < 100) begin @(negedge clk); n++; end
        check("vsync_rise_latency", n, CD);
    endtask

    task automatic wait_vs_rise(string name);
        int n = 0;
        logic prev = vsync;
        forever begin
            @(negedge clk);
            n++;
            if (vsync && !prev) break;
            prev = vsync;
            if (n > 5000) begin check(name, 0, 1); break; end
        end
    endtask

    task automatic wait_href_rise(string name);
        int n = 0;
        logic prev = href;
        forever begin
            @(negedge clk);
            n++;
            if (href && !prev) break;
            prev = href;
            if (n > 5000) begin check(name, 0, 1); break; end
        end
    endtask

    task automatic wait_done(string name);
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (frame_done) break;
            if (n > 5000) begin check(name, 0, 1); break; end
        end
    endtask

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [15:0] rgb;
    } spot_t;

    spot_t spots [18];
    int    pats [6] = '{3, 3, 3, 0, 2, 1};

    initial begin
        int rises, vs_seen;
        logic pq;

        spots[0]  = '{0, 0, 0, 16'h001F};
        spots[1]  = '{1, 5, 7, 16'h081E};
        spots[2]  = '{2, 15, 15, 16'h101D};
        spots[3]  = '{3, 0, 0, 16'hFFFF};
        spots[4]  = '{3, 2, 3, 16'hFFE0};
        spots[5]  = '{3, 4, 0, 16'h07FF};
        spots[6]  = '{3, 6, 0, 16'h07E0};
        spots[7]  = '{3, 8, 0, 16'hF81F};
        spots[8]  = '{3, 10, 0, 16'hF800};
        spots[9]  = '{3, 13, 0, 16'h001F};
        spots[10] = '{3, 15, 15, 16'h0000};
        spots[11] = '{4, 0, 8, 16'hFFFF};
        spots[12] = '{4, 8, 8, 16'h0000};
        spots[13] = '{4, 8, 0, 16'hFFFF};
        spots[14] = '{4, 0, 0, 16'h0000};
        spots[15] = '{5, 15, 0, 16'h0861};
        spots[16] = '{5, 4, 0, 16'h0020};
        spots[17] = '{6, 0, 0, 16'h001F};

        // Reset state
        enable = 1'b1;
        pattern_sel = 2'(pats[0]);
        repeat (3) @(negedge clk);
        check("rst_pclk", int'(pclk), 0);
        check("rst_vsync", int'(vsync), 0);
        check("rst_href", int'(href), 0);
        check("rst_data", int'(data), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_frame_done", int'(frame_done), 0);

        // Six back-to-back frames; the next pattern is driven just after each
        // vsync rise, so it must not disturb the frame in progress.
        push_frame(pats[0], 0);
        release_check();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) wait_vs_rise("timeout_vsync");
            if (i < 5) begin
                pattern_sel = 2'(pats[i + 1]);
                push_frame(pats[i + 1], i + 1);
            end else begin
                pattern_sel = 2'd2;
                wait_href_rise("timeout_href");
                enable = 1'b0;
                pattern_sel = 2'd0;
            end
        end
        wait_done("timeout_done");
        check("frame_cnt_after_6", int'(frame_cnt), 6);

        // IDLE: vsync stays low while pclk keeps running
        rises = 0; vs_seen = 0; pq = pclk;
        repeat (10 * CD) begin
            @(negedge clk);
            if (pclk && !pq) rises++;
            if (vsync) vs_seen++;
            pq = pclk;
        end
        check("idle_pclk_rises", rises, 10);
        check("idle_vsync", vs_seen, 0);

        // Restart, then reset in the middle of an active line
        pattern_sel = 2'd3;
        enable = 1'b1;
        push_frame(3, 6);
        wait_vs_rise("timeout_vsync_restart");
        wait_href_rise("timeout_href_restart");
        repeat (5 * CD + 1) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midline_rst_outs", int'({pclk, vsync, href, data, frame_cnt, frame_done}), 0);
        sb.delete();
        push_frame(3, 0);
        repeat (3) @(negedge clk);
        release_check();
        check("frame_cnt_after_rst", int'(frame_cnt), 0);
        wait_href_rise("timeout_href_post_rst");
        enable = 1'b0;
        wait_done("timeout_done_post_rst");
        check("sb_empty", sb.size(), 0);

        for (int i = 0; i < 18; i++)
            check($sformatf("spot_f%0d_x%0d_y%0d", spots[i].f, spots[i].x, spots[i].y),
                  int'(fb[spots[i].f][spots[i].y][spots[i].x]), int'(spots[i].rgb));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
